// File: rtl/bp_pkg.sv
// Shared decode constants, counter type and RV immediate helpers
// for the front-end branch prediction unit.
package bp_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic logic signed [31:0] imm_j(
    input logic [31:0] i
  );
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(
    input logic [31:0] i
  );
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // x1/x5 are the RV link registers for call/return hints
  function automatic logic is_link(
    input logic [4:0] r
  );
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// PC-indexed table of 2-bit saturating counters with
// combinational read and clocked, saturating training.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output ctr_t                       rd_ctr_o,
  input  logic                       upd_en_i,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
  input  logic                       upd_taken_i
);

  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];
  ctr_t cur;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign cur      = ctr_q[upd_idx_i];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en_i) begin
      if (upd_taken_i) begin
        if (cur != CTR_ST) begin
          ctr_d[upd_idx_i] = cur + 2'd1;
        end
      end else begin
        if (cur != CTR_SNT) begin
          ctr_d[upd_idx_i] = cur - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// Front-end predictor: JAL always taken, branches via 2-bit BHT.
// Define BP_RAS_EN to add a circular return-address stack.
module branch_prediction_unit
  import bp_pkg::*;
#(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   advance,
  input  logic                   update_valid,
  input  logic [PC_WIDTH-1:0]    update_pc,
  input  logic                   update_taken,
  output logic [PC_WIDTH-1:0]    next_pc,
  output logic                   overwrite_pc,
  output logic                   predict_taken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  if (INSTR_WIDTH != 32 || BHT_ENTRIES < 2 || RAS_DEPTH < 1 ||
      (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_cfg_err
    $error("branch_prediction_unit: unsupported parameters");
  end

  logic [6:0]          opcode;
  logic                is_jal;
  logic                is_br;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] jal_tgt;
  logic [PC_WIDTH-1:0] br_tgt;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_hit;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    upd_idx;
  ctr_t                rd_ctr;
  logic                unused_bits;

  assign opcode   = instruction[6:0];
  assign is_jal   = (opcode == OP_JAL);
  assign is_br    = (opcode == OP_BRANCH);
  assign pc_plus4 = pc + PC_WIDTH'(4);
  assign jal_tgt  = pc + PC_WIDTH'(imm_j(instruction));
  assign br_tgt   = pc + PC_WIDTH'(imm_b(instruction));
  assign rd_idx   = pc[IDX_W+1:2];
  assign upd_idx  = update_pc[IDX_W+1:2];

  assign unused_bits = ^{update_pc[PC_WIDTH-1:IDX_W+2],
                         update_pc[1:0], advance};

  bp_counter_table #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk_i      (clk),
    .rst_i      (reset),
    .rd_idx_i   (rd_idx),
    .rd_ctr_o   (rd_ctr),
    .upd_en_i   (update_valid),
    .upd_idx_i  (upd_idx),
    .upd_taken_i(update_taken)
  );

`ifdef BP_RAS_EN
  localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [RP_W-1:0]     ptr_q;
  logic [RP_W-1:0]     ptr_d;
  logic [RP_W-1:0]     top_ptr;
  logic [RC_W-1:0]     cnt_q;
  logic [RC_W-1:0]     cnt_d;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic                is_jalr;
  logic                do_push;
  logic                do_pop;

  assign rd      = instruction[11:7];
  assign rs1     = instruction[19:15];
  assign is_jalr = (opcode == OP_JALR);
  assign do_push = (is_jal || is_jalr) && is_link(rd);
  // pop on ret, or on a coroutine swap (both link, different regs)
  assign do_pop  = is_jalr && is_link(rs1) &&
                   ((rd == 5'd0) || (is_link(rd) && rd != rs1));

  assign top_ptr = (ptr_q == '0) ? RP_W'(RAS_DEPTH - 1)
                                 : ptr_q - RP_W'(1);
  assign ras_top = ras_q[top_ptr];
  assign ras_hit = do_pop && (cnt_q != '0);

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (advance) begin
      if (ras_hit) begin
        ptr_d = top_ptr;
        cnt_d = cnt_q - RC_W'(1);
      end
      if (do_push) begin
        ras_d[ptr_d] = pc_plus4;
        ptr_d = (ptr_d == RP_W'(RAS_DEPTH - 1)) ? '0
                                                : ptr_d + RP_W'(1);
        if (cnt_d != RC_W'(RAS_DEPTH)) begin
          cnt_d = cnt_d + RC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif

  always_comb begin
    next_pc       = pc_plus4;
    overwrite_pc  = 1'b0;
    predict_taken = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        is_jal: begin
          next_pc      = jal_tgt;
          overwrite_pc = 1'b1;
        end
        is_br: begin
          if (rd_ctr[1]) begin
            next_pc       = br_tgt;
            overwrite_pc  = 1'b1;
            predict_taken = 1'b1;
          end
        end
        ras_hit: begin
          next_pc      = ras_top;
          overwrite_pc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Bench for branch_prediction_unit: directed literals plus random
// traffic against a behavioural model (RAS checks with BP_RAS_EN).
module tb_branch_prediction_unit;

  localparam int PCW  = 64;
  localparam int BHT  = 64;
  localparam int RASD = 4;

  localparam logic [31:0] JAL1 = 32'h008000EF;
  localparam logic [31:0] BEQ  = 32'h00000863;
  localparam logic [31:0] RET  = 32'h00008067;

  logic           clk = 1'b0;
  logic           reset;
  logic [PCW-1:0] pc;
  logic [31:0]    instruction;
  logic           advance;
  logic           update_valid;
  logic [PCW-1:0] update_pc;
  logic           update_taken;
  logic [PCW-1:0] next_pc;
  logic           overwrite_pc;
  logic           predict_taken;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int          mctr [BHT];
  logic [63:0] ras [$];

  always #5 clk = ~clk;

  branch_prediction_unit #(
    .PC_WIDTH   (PCW),
    .INSTR_WIDTH(32),
    .BHT_ENTRIES(BHT),
    .RAS_DEPTH  (RASD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instruction  (instruction),
    .advance      (advance),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .next_pc      (next_pc),
    .overwrite_pc (overwrite_pc),
    .predict_taken(predict_taken)
  );

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit link(logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  function automatic longint jimm(logic [31:0] i);
    longint v;
    v = longint'(i[30:21]) * 2 + longint'(i[20]) * 2048 +
        longint'(i[19:12]) * 4096;
    if (i[31]) v = v - 1048576;
    return v;
  endfunction

  function automatic longint bimm(logic [31:0] i);
    longint v;
    v = longint'(i[11:8]) * 2 + longint'(i[30:25]) * 32 +
        longint'(i[7]) * 2048;
    if (i[31]) v = v - 4096;
    return v;
  endfunction

  function automatic int idx_of(logic [63:0] a);
    return int'((a >> 2) % BHT);
  endfunction

  function automatic bit is_pop(logic [31:0] i);
    return i[6:0] == 7'h67 && link(i[19:15]) &&
           (i[11:7] == 5'd0 || (link(i[11:7]) && i[11:7] != i[19:15]));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BHT; i++) mctr[i] = 1;
    ras.delete();
  endfunction

  function automatic void model_predict(output logic [63:0] np,
                                        output logic ow,
                                        output logic pt);
    np = pc + 64'd4;
    ow = 1'b0;
    pt = 1'b0;
    if (reset) return;
    if (instruction[6:0] == 7'h6F) begin
      np = pc + 64'(jimm(instruction));
      ow = 1'b1;
    end else if (instruction[6:0] == 7'h63) begin
      if (mctr[idx_of(pc)] >= 2) begin
        np = pc + 64'(bimm(instruction));
        ow = 1'b1;
        pt = 1'b1;
      end
    end
`ifdef BP_RAS_EN
    else if (is_pop(instruction) && ras.size() > 0) begin
      np = ras[$];
      ow = 1'b1;
    end
`endif
  endfunction

  function automatic void model_update();
    int k;
    if (reset) return;
    if (update_valid) begin
      k = idx_of(update_pc);
      if (update_taken) mctr[k] = (mctr[k] == 3) ? 3 : mctr[k] + 1;
      else              mctr[k] = (mctr[k] == 0) ? 0 : mctr[k] - 1;
    end
`ifdef BP_RAS_EN
    if (advance) begin
      if (is_pop(instruction) && ras.size() > 0) void'(ras.pop_back());
      if ((instruction[6:0] == 7'h6F || instruction[6:0] == 7'h67) &&
          link(instruction[11:7])) begin
        ras.push_back(pc + 64'd4);
        if (ras.size() > RASD) void'(ras.pop_front());
      end
    end
`endif
  endfunction

  always @(negedge clk) begin
    logic [63:0] np;
    logic        ow;
    logic        pt;
    if (chk_on) begin
      model_predict(np, ow, pt);
      chk("model next_pc", next_pc, np);
      chk("model overwrite_pc", 64'(overwrite_pc), 64'(ow));
      chk("model predict_taken", 64'(predict_taken), 64'(pt));
    end
  end

  task automatic drive(input logic [63:0] p, input logic [31:0] ins,
                       input logic adv, input logic uv,
                       input logic [63:0] up, input logic ut,
                       input logic rs);
    @(posedge clk);
    model_update();
    #1;
    pc           = p;
    instruction  = ins;
    advance      = adv;
    update_valid = uv;
    update_pc    = up;
    update_taken = ut;
    if (rs && !reset) model_reset();
    reset = rs;
  endtask

  task automatic lit(input string nm, input logic [63:0] np,
                     input logic ow, input logic pt);
    @(negedge clk);
    chk({nm, " next_pc"}, next_pc, np);
    chk({nm, " overwrite_pc"}, 64'(overwrite_pc), 64'(ow));
    chk({nm, " predict_taken"}, 64'(predict_taken), 64'(pt));
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    r   = $urandom();
    rd  = pick_reg();
    rs1 = pick_reg();
    case ($urandom_range(0, 7))
      0, 1:    return {r[31:12], rd, 7'b1101111};
      2, 3:    return {r[31:7], 7'b1100011};
      4:       return {r[31:20], rs1, 3'b000, rd, 7'b1100111};
      5:       return 32'h0;
      6:       return {r[31:7], 7'b0010011};
      default: return RET;
    endcase
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] hi;
    if ($urandom_range(0, 9) == 0)
      return 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
    hi = 64'($urandom_range(0, 3)) << 40;
    return hi | (64'h2000 + 64'(4 * $urandom_range(0, 15)));
  endfunction

  initial begin
    reset        = 1'b1;
    pc           = 64'h1000;
    instruction  = JAL1;
    advance      = 1'b0;
    update_valid = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;
    model_reset();
    chk_on = 1'b1;

    lit("reset defaults", 64'h1004, 1'b0, 1'b0);
    drive(64'h1000, JAL1, 0, 0, 0, 0, 0);
    lit("jal", 64'h1008, 1'b1, 1'b0);
    drive(64'h2000, BEQ, 0, 0, 0, 0, 0);
    lit("branch cold", 64'h2004, 1'b0, 1'b0);
    drive(64'h2000, BEQ, 0, 1, 64'h2000, 1, 0);
    lit("same-cycle update", 64'h2004, 1'b0, 1'b0);
    drive(64'h2000, BEQ, 0, 0, 0, 0, 0);
    lit("trained once", 64'h2010, 1'b1, 1'b1);
    drive(64'h2000, BEQ, 0, 1, 64'h2000, 1, 0);
    lit("trained twice", 64'h2010, 1'b1, 1'b1);
    drive(64'h2100, BEQ, 0, 0, 0, 0, 0);
    lit("alias", 64'h2110, 1'b1, 1'b1);
    drive(64'h2004, BEQ, 0, 0, 0, 0, 0);
    lit("neighbour", 64'h2008, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(64'h2000, BEQ, 0, 1, 64'h2000, 0, 0);
    drive(64'h2000, BEQ, 0, 0, 0, 0, 0);
    lit("untrained", 64'h2004, 1'b0, 1'b0);
    drive(64'h2000, BEQ, 0, 1, 64'h2000, 1, 0);
    drive(64'h2000, BEQ, 0, 0, 0, 0, 0);
    lit("saturated at 00", 64'h2004, 1'b0, 1'b0);

`ifdef BP_RAS_EN
    drive(64'h3000, JAL1, 1, 0, 0, 0, 0);
    lit("call", 64'h3008, 1'b1, 1'b0);
    drive(64'h3008, RET, 1, 0, 0, 0, 0);
    lit("ret", 64'h3004, 1'b1, 1'b0);
    drive(64'h3008, RET, 1, 0, 0, 0, 0);
    lit("ret empty", 64'h300C, 1'b0, 1'b0);
    drive(64'h3000, JAL1, 1, 0, 0, 0, 0);
    drive(64'h3008, RET, 1, 0, 0, 0, 1);
    lit("ret in reset", 64'h300C, 1'b0, 1'b0);
    drive(64'h3008, RET, 1, 0, 0, 0, 0);
    lit("ret after reset", 64'h300C, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      drive(rand_pc(), rand_instr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_pc(),
            1'($urandom_range(0, 1)), i == 1500);
    end
    drive(64'h4000, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_prediction_unit.md
Name: branch_prediction_unit

Overview:
- Front-end branch predictor between the fetch/cache stage and decode.
- Each cycle it examines the fetched {pc, instruction} pair and decides whether to redirect fetch.
  - JAL: always taken.
  - Conditional branches: predicted by a PC-indexed table of 2-bit saturating counters.
  - JALR: not predicted in the base configuration.
- The back end trains the counter table through a resolve port.

Parameters:
PC_WIDTH, 64, width of pc and next_pc
INSTR_WIDTH, 32, RV instruction width (fixed at 32)
BHT_ENTRIES, 64, number of 2-bit counters (power of 2, >=2)
RAS_DEPTH, 4, return-stack entries (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pc  in  PC_WIDTH  address of the fetched instruction
instruction  in  32  fetched instruction word
advance  in  1  pair is accepted this cycle (front end not stalled); qualifies state changes
update_valid  in  1  a conditional branch resolved this cycle
update_pc  in  PC_WIDTH  pc of the resolved branch
update_taken  in  1  actual branch outcome
next_pc  out  PC_WIDTH  predicted fetch target
overwrite_pc  out  1  1 = redirect fetch to next_pc
predict_taken  out  1  conditional-branch prediction bit (0 for other instructions)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- On reset, every counter goes to 2'b01 (weakly not-taken). With the optional feature, the RAS pointer and count clear to 0.
- Outputs are combinational from pc, instruction and current table state, so latency is 0 cycles. Table and RAS update on the posedge clk.
- Default outputs: next_pc = pc + 4, overwrite_pc = 0, predict_taken = 0. These hold also during reset.
- Decode uses opcode = instruction[6:0].
- JAL (7'b1101111):
  - imm_j = sign-extend {i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - next_pc = pc + imm_j; overwrite_pc = 1.
- BRANCH (7'b1100011):
  - imm_b = sign-extend {i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - idx = pc[log2(BHT_ENTRIES)+1 : 2].
  - If counter[idx][1] = 1: predict_taken = 1, overwrite_pc = 1, next_pc = pc + imm_b.
- JALR and all other opcodes, including instruction = 0, use the defaults.
- Arithmetic is modulo 2^PC_WIDTH; wrap-around is permitted.
- Training: when update_valid is high, at the clock edge counter[update_pc index] increments if update_taken = 1, otherwise decrements. It saturates at 2'b11 and 2'b00.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value.
- Aliasing: PCs differing only above the index bits share a counter. This is intended.
- advance does not gate training. It gates only RAS changes.

Optional Feature:
- Macro: BP_RAS_EN. When defined, a RAS_DEPTH-entry circular return-address stack is built in.
- Push: JAL or JALR with rd in {x1, x5}, while advance = 1, pushes pc + 4. When full, the oldest entry is overwritten.
- Pop: JALR with rd = x0 and rs1 in {x1, x5}, while advance = 1, pops.
  - If the stack is non-empty: next_pc = top entry, overwrite_pc = 1.
  - If empty: no prediction (defaults).
- Simultaneous pop and push (JALR with rd = link and rs1 = link, rs1 != rd): pop then push. The prediction is the old top.
- Without the macro, JALR is never predicted and no RAS storage exists.

Decomposition:
- Shared package bp_pkg holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH;
  - the counter type (2-bit);
  - immediate-extraction functions imm_b and imm_j.
- One sub-module, bp_counter_table, holds the BHT storage, async reset, saturating update and combinational read.
- The RAS stays inline under `ifdef BP_RAS_EN.

Test Plan:
- JAL: reset, pc = 0x1000, instruction = 0x008000EF (jal x1, 8) -> overwrite_pc = 1, next_pc = 0x1008, predict_taken = 0.
- Branch after reset: pc = 0x2000, instruction = 0x00000863 (beq x0, x0, 16) -> overwrite_pc = 0, next_pc = 0x2004.
- Training: two updates with update_pc = 0x2000, update_taken = 1 -> same branch now overwrite_pc = 1, next_pc = 0x2010. Three not-taken updates -> not predicted again, and the counter is checked saturated at 00.
- Aliasing: train pc 0x2000 taken, then look up the branch at pc 0x2100 (64 entries, same index) -> predicted taken. The branch at pc 0x2004 stays not-taken.
- Same-cycle read/update: counter at 01, lookup and taken-update on the same index -> this cycle not taken, next cycle taken.
- BP_RAS_EN: JAL x1 at 0x3000 with advance = 1, then 0x00008067 (ret) -> next_pc = 0x3004, overwrite_pc = 1. A second ret with an empty stack -> overwrite_pc = 0. Assert reset mid-sequence -> stack empties immediately.
